// File: rtl/waveform_capture.sv
// waveform_capture: threshold/force-triggered ADC waveform capture with pre-trigger history and pulse height.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module waveform_capture #(
  parameter int NSAMPLES = 32,
  parameter int PRETRIG  = 4,
  parameter int HOLDOFF  = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [13:0]              adc_data,
  input  logic                     sample_en,
  input  logic [13:0]              threshold,
  input  logic                     force_trigger,
  output logic [NSAMPLES*14-1:0]   waveform,
  output logic                     acquire,
  output logic [15:0]              PulseHeight,
  output logic [1:0]               state,
  output logic [15:0]              triggerCount
);

  localparam int IDXW  = $clog2(NSAMPLES + 1);
  localparam int HOLDW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t           cur_state, nxt_state;
  logic [13:0]      hist [PRETRIG];
  logic [13:0]      wf [NSAMPLES];
  logic [IDXW-1:0]  idx;
  logic [HOLDW-1:0] hold_cnt;
  logic [13:0]      run_max;

  logic             trig;
  logic             last_write;
  logic [13:0]      seed_max;
  logic [13:0]      max_next;
  logic [13:0]      base_next;

  assign trig = sample_en &&
                (force_trigger || ((hist[PRETRIG-1] < threshold) && (adc_data >= threshold)));

  always_comb begin
    seed_max = adc_data;
    for (int i = 0; i < PRETRIG; i++) begin
      if (hist[i] > seed_max) seed_max = hist[i];
    end
  end

  // The final write can be the trigger itself when the pre-trigger window spans all but one slot.
  always_comb begin
    nxt_state  = cur_state;
    last_write = 1'b0;
    case (cur_state)
      FILL: begin
        if (sample_en && idx == IDXW'(PRETRIG - 1)) nxt_state = ARMED;
      end
      ARMED: begin
        if (trig) begin
          if (PRETRIG == NSAMPLES - 1) begin
            nxt_state  = HOLD;
            last_write = 1'b1;
          end else begin
            nxt_state = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (sample_en && idx == IDXW'(NSAMPLES - 1)) begin
          nxt_state  = HOLD;
          last_write = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLDW'(HOLDOFF - 1)) nxt_state = ARMED;
      end
      default: nxt_state = FILL;
    endcase
    max_next  = (cur_state == ARMED) ? seed_max :
                ((adc_data > run_max) ? adc_data : run_max);
    base_next = (cur_state == ARMED) ? hist[0] : wf[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state    <= FILL;
      acquire      <= 1'b1;
      idx          <= '0;
      hold_cnt     <= '0;
      run_max      <= '0;
      PulseHeight  <= '0;
      triggerCount <= '0;
      for (int i = 0; i < PRETRIG; i++)  hist[i] <= '0;
      for (int i = 0; i < NSAMPLES; i++) wf[i]   <= '0;
    end else begin
      cur_state <= nxt_state;
      acquire   <= (nxt_state != HOLD);

      if (sample_en) begin
        for (int i = 0; i < PRETRIG - 1; i++) hist[i] <= hist[i+1];
        hist[PRETRIG-1] <= adc_data;
      end

      case (cur_state)
        FILL: begin
          if (sample_en) idx <= (nxt_state == ARMED) ? '0 : idx + IDXW'(1);
        end
        ARMED: begin
          if (trig) begin
            for (int i = 0; i < PRETRIG; i++) wf[i] <= hist[i];
            wf[PRETRIG] <= adc_data;
            idx         <= IDXW'(PRETRIG + 1);
            run_max     <= seed_max;
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            for (int i = PRETRIG + 1; i < NSAMPLES; i++) begin
              if (idx == IDXW'(i)) wf[i] <= adc_data;
            end
            idx     <= idx + IDXW'(1);
            run_max <= max_next;
          end
        end
        HOLD: hold_cnt <= hold_cnt + HOLDW'(1);
        default: ;
      endcase

      if (last_write) begin
        PulseHeight  <= {2'b00, max_next - base_next};
        triggerCount <= triggerCount + 16'd1;
        hold_cnt     <= '0;
      end
    end
  end

  for (genvar g = 0; g < NSAMPLES; g++) begin : g_wf
    assign waveform[g*14 +: 14] = wf[g];
  end

  assign state = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_waveform_capture.sv
// tb_waveform_capture: table-driven capture scenarios with a scoreboard of expected frozen waveforms.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_waveform_capture;

  localparam int NS = 32;
  localparam int PT = 4;
  localparam int HO = 1024;
  localparam int W  = NS * 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [13:0]   adc_data;
  logic          sample_en;
  logic [13:0]   threshold;
  logic          force_trigger;
  logic [W-1:0]  waveform;
  logic          acquire;
  logic [15:0]   PulseHeight;
  logic [1:0]    state;
  logic [15:0]   triggerCount;

  waveform_capture #(.NSAMPLES(NS), .PRETRIG(PT), .HOLDOFF(HO)) dut (
    .clk          (clk),
    .reset        (reset),
    .adc_data     (adc_data),
    .sample_en    (sample_en),
    .threshold    (threshold),
    .force_trigger(force_trigger),
    .waveform     (waveform),
    .acquire      (acquire),
    .PulseHeight  (PulseHeight),
    .state        (state),
    .triggerCount (triggerCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] wf;
    logic [15:0]  ph;
    logic [15:0]  cnt;
    logic [13:0]  w0;
    logic [13:0]  w4;
    logic [13:0]  w31;
    logic [15:0]  hph;
  } exp_t;

  typedef struct {
    int pre_val;
    int start;
    int step;
    int thr;
    int frc;
    int trig_j;
    int gap;
    int w0;
    int w4;
    int w31;
    int ph;
  } vec_t;

  exp_t         sb[$];
  exp_t         pend;
  exp_t         got;
  logic [13:0]  hq[$];
  logic [W-1:0] cwf;
  int           cn;
  bit           collecting = 1'b0;
  int           exp_cnt = 0;
  int           compared = 0;
  int           mismatched = 0;
  vec_t         vt[4];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] wf_ph(input logic [W-1:0] w);
    logic [13:0] mx;
    mx = w[13:0];
    for (int i = 1; i < NS; i++) if (w[i*14 +: 14] > mx) mx = w[i*14 +: 14];
    return {2'b00, mx - w[13:0]};
  endfunction

  // Called from a negedge; the sample is taken on the following posedge.
  task automatic strobe(input logic [13:0] v, input int gap);
    if (collecting) begin
      cwf[cn*14 +: 14] = v;
      cn++;
      if (cn == NS) begin
        pend.wf = cwf;
        pend.ph = wf_ph(cwf);
        sb.push_back(pend);
        collecting = 1'b0;
      end
    end
    hq.push_back(v);
    if (hq.size() > PT) void'(hq.pop_front());
    adc_data  = v;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    for (int k = 1; k < gap; k++) @(negedge clk);
  endtask

  task automatic arm(input int w0, input int w4, input int w31, input int ph);
    exp_cnt++;
    pend.cnt = 16'(exp_cnt);
    pend.w0  = 14'(w0);
    pend.w4  = 14'(w4);
    pend.w31 = 14'(w31);
    pend.hph = 16'(ph);
    cwf = '0;
    for (int i = 0; i < PT; i++) cwf[i*14 +: 14] = hq[i];
    cn = PT;
    collecting = 1'b1;
  endtask

  task automatic wait_armed();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      if (acquire && (state == 2'd0 || state == 2'd1)) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check("wait_armed_timeout", W'(state), W'(1));
  endtask

  bit prev_acq = 1'b1;
  int low_cnt  = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_acq && !acquire) begin
        if (sb.size() == 0) begin
          check("unexpected_capture", W'(triggerCount), W'(exp_cnt));
        end else begin
          got = sb.pop_front();
          check("waveform",      waveform,                   got.wf);
          check("wf0",           W'(waveform[13:0]),         W'(got.w0));
          check("wf4",           W'(waveform[4*14 +: 14]),   W'(got.w4));
          check("wf31",          W'(waveform[31*14 +: 14]),  W'(got.w31));
          check("ph_model",      W'(PulseHeight),            W'(got.ph));
          check("ph_table",      W'(PulseHeight),            W'(got.hph));
          check("trigger_count", W'(triggerCount),           W'(got.cnt));
          check("state_hold",    W'(state),                  W'(3));
        end
        low_cnt = 1;
      end else if (!acquire) begin
        low_cnt++;
      end else if (!prev_acq) begin
        check("hold_length", W'(low_cnt), W'(HO));
      end
    end
    prev_acq = acquire;
  end

  initial begin
    int s;
    vt[0] = '{100,  200,  100,  250, 0, 1, 3,  100,  300,  3000,  2900};
    vt[1] = '{1234, 1234, 0,    0,   1, 0, 2,  1234, 1234, 1234,  0};
    vt[2] = '{0,    0,    4000, 1000,0, 1, 1,  0,    4000, 16383, 16383};
    vt[3] = '{500,  600,  100,  700, 0, 1, 2,  500,  700,  3400,  2900};

    reset = 1'b1; adc_data = '0; sample_en = 1'b0; threshold = '0; force_trigger = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state",   W'(state),        W'(0));
    check("rst_acquire", W'(acquire),      W'(1));
    check("rst_ph",      W'(PulseHeight),  W'(0));
    check("rst_cnt",     W'(triggerCount), W'(0));
    check("rst_wf",      waveform,         W'(0));
    reset = 1'b0;
    @(negedge clk);

    // Flat input above threshold never crosses
    threshold = 14'd4000;
    for (int i = 0; i < 40; i++) strobe(14'd5000, 1);
    check("flat_state",   W'(state),        W'(1));
    check("flat_acquire", W'(acquire),      W'(1));
    check("flat_cnt",     W'(triggerCount), W'(0));

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      wait_armed();
      threshold = 14'(vt[v].thr);
      for (int i = 0; i < PT; i++) strobe(14'(vt[v].pre_val), vt[v].gap);
      for (int j = 0; j <= vt[v].trig_j + NS - 1 - PT; j++) begin
        s = vt[v].start + j * vt[v].step;
        if (s > 16383) s = 16383;
        if (j == vt[v].trig_j) arm(vt[v].w0, vt[v].w4, vt[v].w31, vt[v].ph);
        force_trigger = (j == vt[v].trig_j) && (vt[v].frc != 0);
        strobe(14'(s), vt[v].gap);
        force_trigger = 1'b0;
      end
      check("vec_hold_acq", W'(acquire), W'(0));
    end

    // Crossing inside HOLD is ignored; crossing on first ARMED strobe captures
    threshold = 14'd5000;
    strobe(14'd4000, 2);
    strobe(14'd6000, 2);
    check("hold_ignores_state", W'(state),   W'(3));
    check("hold_ignores_acq",   W'(acquire), W'(0));
    strobe(14'd4100, 2);
    strobe(14'd4200, 2);
    wait_armed();
    arm(4000, 6000, 6027, 2027);
    strobe(14'd6000, 1);
    for (int j = 1; j < NS - PT; j++) strobe(14'(6000 + j), 1);

    // Asynchronous reset in the middle of a capture (index 10)
    wait_armed();
    threshold = '0;
    force_trigger = 1'b1;
    strobe(14'd777, 1);
    force_trigger = 1'b0;
    for (int j = 0; j < 5; j++) strobe(14'(778 + j), 1);
    check("midcap_state", W'(state), W'(2));
    #2 reset = 1'b1;
    #1;
    check("arst_state",   W'(state),        W'(0));
    check("arst_acquire", W'(acquire),      W'(1));
    check("arst_wf",      waveform,         W'(0));
    check("arst_ph",      W'(PulseHeight),  W'(0));
    check("arst_cnt",     W'(triggerCount), W'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("sb_empty", W'(sb.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
